time_keeper: RTL and testbench
==============================

# time_keeper

Timekeeping core feeding the seven-segment display stage. It divides the system clock into a 1 s tick and keeps a 24-hour HH:MM:SS count in packed BCD. Two debounced push-buttons set hours and minutes. Outputs are registered BCD digits plus a blink flag, consumed directly by the display multiplexer.

## Interface
- TICK_DIV, 65536, clock cycles per second tick (≥2)
- DEBOUNCE_CYCLES, 1024, consecutive stable synchronized samples required to accept a button level change (≥1)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- run_en  in  1  1 = prescaler counts; 0 = prescaler and time hold
- btn_mode  in  1  raw, asynchronous, active-high mode button
- btn_inc  in  1  raw, asynchronous, active-high increment button
- hour_bcd  out  8  tens[7:4], units[3:0], 00–23
- min_bcd  out  8  00–59
- sec_bcd  out  8  00–59
- sec_tick  out  1  one-cycle pulse, high in the cycle after a seconds update
- set_field  out  2  0 = RUN, 1 = SET_H, 2 = SET_M (current FSM state)
- blink  out  1  display enable for the field being set; constant 1 in RUN

## Operation
- Prescaler: 0..TICK_DIV-1 counter, advances while run_en=1, wraps to 0. A wrap edge is a "tick".
- RUN state, tick: sec +1 in BCD. 59→00 carries to min. min 59→00 carries to hour. hour 23→00. 23:59:59→00:00:00 in a single edge.
- Buttons: two-flop synchronizer → button_debounce → rising-edge detect → one-cycle press pulse.
- FSM: RUN →(mode)→ SET_H →(mode)→ SET_M →(mode)→ RUN. Encoding is 0/1/2; 3 is unreachable and recovers to RUN.
- SET_H, inc press: hour +1, 23→00, no carry.
- SET_M, inc press: min +1, 59→00, no carry into hour.
- Inc press in RUN: ignored.
- In SET_H/SET_M, ticks do not change the time. The prescaler keeps running, gated by run_en.
- SET_M→RUN transition: sec cleared to 00 and prescaler cleared to 0 on the same edge, so the next second starts exactly TICK_DIV cycles later.
- blink: a blink_phase register toggles on every tick. blink = (state==RUN) | blink_phase.
- Simultaneous mode and inc presses in one cycle: mode wins, inc discarded.
- run_en=0: prescaler frozen, no ticks. Button handling and the FSM remain active.

## Timing
- Reset values:
  - hour/min/sec = 00
  - prescaler = 0
  - state = RUN
  - sec_tick = 0
  - blink_phase = 0, so blink = 1
  - debounced levels = 0
  - synchronizers = 0
- First tick: on the TICK_DIV-th rising edge after reset release with run_en=1. sec_bcd = 01 and sec_tick = 1 in the same following cycle.
- sec_tick is high for exactly one cycle per RUN tick. It is never asserted in SET states.
- Button latency: 2 sync cycles + DEBOUNCE_CYCLES stable + 1 edge detect. A field update or state change is visible on the edge DEBOUNCE_CYCLES+3 cycles after the raw input rises (constant; the bench checks exactly).
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no press. Holding a button produces exactly one press; no auto-repeat.
- Asynchronous reset mid-operation returns every register to its reset value immediately. A button still held at release is reported as a press once debounced.

## Structure
- Package clock_pkg:
  - FSM state constants ST_RUN/ST_SET_H/ST_SET_M (2-bit)
  - BCD limits: SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23
  - Shared by time_keeper and the display stage
- Sub-module button_debounce, instantiated twice:
  - parameter DEBOUNCE_CYCLES
  - ports clock, reset, raw_in, level_out, press_pulse
  - contains the synchronizer, the stability counter and the edge detect
- BCD increment-with-wrap is a shared function, used for both tick carry and set increments.

## Test plan
- TICK_DIV=4, run_en=1, hold 12 cycles after reset → sec_bcd 00→01→02→03 on edges 4, 8, 12; sec_tick high in each following cycle only.
- Preload 23:59:58 via set mode plus ticks → two ticks later 00:00:00, min/hour carries on the same edge as sec.
- DEBOUNCE_CYCLES=4: btn_mode high 3 synchronized cycles then low → no state change. Held high → set_field=1 exactly 7 cycles after the rise.
- SET_H, 24 inc presses from 05 → hour returns to 05, min/sec unchanged, ticks ignored, blink toggles each tick.
- SET_M at min=59, inc → 00 with hour unchanged. Then mode → RUN, sec=00, first tick exactly TICK_DIV cycles later.
- Mode and inc pulses aligned in the same cycle in SET_H → state SET_M, hour unchanged. Assert reset mid-count → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared timekeeping definitions: FSM state encoding, BCD field limits and
// the BCD increment-with-wrap helper used by the time and set logic.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2
  } state_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    if (val == max) return 8'h00;
    if (val[3:0] == 4'd9) return {val[7:4] + 4'd1, 4'd0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge detect producing a single-cycle press pulse per accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive samples disagreeing with the accepted level; the press
  // pulse is raised on the same edge a new high level is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_cnt  <= '0;
      level_out   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync_p1 == level_out) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt  <= '0;
        level_out   <= sync_p1;
        press_pulse <= sync_p1;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD clock with 1 s prescaler, mode/increment buttons for setting
// hours and minutes, and a blink flag for the field being edited.
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_tick,
  output logic [1:0] set_field,
  output logic       blink
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc;
  logic             tick;
  logic             blink_phase;
  logic             mode_press;
  logic             inc_press;
  logic             mode_level;
  logic             inc_level;
  logic             unused_levels;
  logic             clear_sec;
  state_t           state;
  state_t           state_nxt;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (btn_mode),
    .level_out  (mode_level),
    .press_pulse(mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (btn_inc),
    .level_out  (inc_level),
    .press_pulse(inc_press)
  );

  assign unused_levels = mode_level ^ inc_level;

  assign tick = run_en && (presc == PRE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Mode press always advances the state; leaving SET_M restarts the second.
  always_comb begin
    state_nxt = state;
    clear_sec = 1'b0;
    case (state)
      ST_RUN:   if (mode_press) state_nxt = ST_SET_H;
      ST_SET_H: if (mode_press) state_nxt = ST_SET_M;
      ST_SET_M: if (mode_press) begin
        state_nxt = ST_RUN;
        clear_sec = 1'b1;
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         presc <= '0;
    else if (clear_sec) presc <= '0;
    else if (run_en)    presc <= tick ? '0 : presc + PRE_W'(1);
  end

  // Mode press takes priority over a coincident increment press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour_bcd    <= 8'h00;
      min_bcd     <= 8'h00;
      sec_bcd     <= 8'h00;
      sec_tick    <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      sec_tick <= tick && (state == ST_RUN);
      if (tick) blink_phase <= ~blink_phase;
      case (state)
        ST_RUN: if (tick) begin
          sec_bcd <= bcd_inc(sec_bcd, SEC_MAX);
          if (sec_bcd == SEC_MAX) begin
            min_bcd <= bcd_inc(min_bcd, MIN_MAX);
            if (min_bcd == MIN_MAX) hour_bcd <= bcd_inc(hour_bcd, HOUR_MAX);
          end
        end
        ST_SET_H: if (inc_press && !mode_press) hour_bcd <= bcd_inc(hour_bcd, HOUR_MAX);
        ST_SET_M: begin
          if (clear_sec)      sec_bcd <= 8'h00;
          else if (inc_press) min_bcd <= bcd_inc(min_bcd, MIN_MAX);
        end
        default: ;
      endcase
    end
  end

  assign set_field = state;
  assign blink     = (state == ST_RUN) | blink_phase;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed sequences plus random button/run_en traffic,
// checked every cycle against a seconds-of-day reference model.
`timescale 1ns/1ps
module tb_time_keeper;

  localparam int TD = 4;
  localparam int DB = 4;
  localparam logic [31:0] RST_VEC = {3'b0, 24'h000000, 1'b0, 2'd0, 1'b1};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run_en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       sec_tick;
  logic [1:0] set_field;
  logic       blink;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  time_keeper #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clock    (clock),
    .reset    (reset),
    .run_en   (run_en),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .sec_tick (sec_tick),
    .set_field(set_field),
    .blink    (blink)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic logic [31:0] outvec();
    return {3'b0, hour_bcd, min_bcd, sec_bcd, sec_tick, set_field, blink};
  endfunction

  // Reference model: time as seconds of day, buttons as a window of raw samples
  int            m_t = 0;
  int            m_mode = 0;
  int            m_presc = 0;
  bit            m_blink = 1'b0;
  bit            m_tick = 1'b0;
  bit [DB+1:0]   m_hist[2];
  bit            m_lvl[2];
  bit            m_pend[2];
  bit            mdl_tk, mdl_mp, mdl_ip;
  bit            mdl_raw[2];
  int            mdl_h, mdl_m, mdl_s;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_t = 0; m_mode = 0; m_presc = 0; m_blink = 0; m_tick = 0;
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = '0; m_lvl[b] = 0; m_pend[b] = 0;
      end
    end else begin
      mdl_tk = run_en && (m_presc == TD - 1);
      if (run_en) m_presc = (m_presc + 1) % TD;
      mdl_mp = m_pend[0];
      mdl_ip = m_pend[1];
      m_tick = 0;
      if (m_mode == 0 && mdl_tk) begin
        m_t = (m_t + 1) % 86400;
        m_tick = 1;
      end
      if (mdl_tk) m_blink = !m_blink;
      mdl_h = m_t / 3600; mdl_m = (m_t / 60) % 60; mdl_s = m_t % 60;
      if (mdl_mp) begin
        if (m_mode == 2) begin mdl_s = 0; m_presc = 0; end
        m_mode = (m_mode + 1) % 3;
      end else if (mdl_ip) begin
        if (m_mode == 1) mdl_h = (mdl_h + 1) % 24;
        else if (m_mode == 2) mdl_m = (mdl_m + 1) % 60;
      end
      m_t = mdl_h * 3600 + mdl_m * 60 + mdl_s;
      mdl_raw[0] = btn_mode;
      mdl_raw[1] = btn_inc;
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = {m_hist[b][DB:0], mdl_raw[b]};
        m_pend[b] = 0;
        if (!m_lvl[b] && (&m_hist[b][DB+1:2])) begin
          m_lvl[b] = 1; m_pend[b] = 1;
        end else if (m_lvl[b] && !(|m_hist[b][DB+1:2])) begin
          m_lvl[b] = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en)
      chk("model", outvec(),
          {3'b0, to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
           m_tick, 2'(m_mode), (m_mode == 0) | m_blink});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input bit mode, input bit inc);
    btn_mode = mode;
    btn_inc  = inc;
    step(DB + 3);
    btn_mode = 0;
    btn_inc  = 0;
    step(DB + 4);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sec_tick && n < 8 * TD);
    chk(tag, sec_tick, 1'b1);
  endtask

  logic [15:0] snap_ms;
  int          tog;
  logic        prev_blink;

  initial begin
    run_en = 1;
    #2 reset = 0;
    chk_en = 1;
    step(3);
    chk("reset_state", outvec(), RST_VEC);
    @(negedge clock);
    reset = 1;

    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("sec_seq", sec_bcd, i / 4);
      chk("tick_seq", sec_tick, (i % 4) == 0);
    end

    btn_mode = 1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("mode_latency", set_field, (i >= 7) ? 1 : 0);
    end
    btn_mode = 0;
    step(8);

    btn_mode = 1;
    step(3);
    btn_mode = 0;
    step(12);
    chk("glitch", set_field, 1);

    for (int i = 0; i < 23; i++) press(0, 1);
    chk("hour_23", hour_bcd, 8'h23);
    press(1, 0);
    for (int i = 0; i < 59; i++) press(0, 1);
    chk("min_59", {hour_bcd, min_bcd}, 16'h2359);
    press(1, 0);
    chk("back_run", set_field, 0);

    begin
      int n;
      n = 0;
      while (sec_bcd != 8'h58 && n < 400) begin
        step(1);
        n++;
      end
      chk("reach_58", {hour_bcd, min_bcd, sec_bcd}, 24'h235958);
    end
    wait_tick("tick_59");
    chk("at_59", {hour_bcd, min_bcd, sec_bcd}, 24'h235959);
    wait_tick("tick_roll");
    chk("rollover", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);

    press(1, 0);
    chk("enter_seth", set_field, 1);
    snap_ms = {to_bcd((m_t / 60) % 60), to_bcd(m_t % 60)};
    for (int i = 0; i < 5; i++) press(0, 1);
    chk("hour_05", hour_bcd, 8'h05);
    for (int i = 0; i < 24; i++) press(0, 1);
    chk("hour_wrap24", hour_bcd, 8'h05);
    chk("seth_ms_held", {min_bcd, sec_bcd}, snap_ms);

    tog = 0;
    prev_blink = blink;
    for (int i = 0; i < 4 * TD; i++) begin
      step(1);
      if (blink != prev_blink) tog++;
      prev_blink = blink;
    end
    chk("blink_toggles", tog, 4);

    press(1, 1);
    chk("simul_field", set_field, 2);
    chk("simul_hour", hour_bcd, 8'h05);

    for (int i = 0; i < 59; i++) press(0, 1);
    chk("setm_59", min_bcd, 8'h59);
    press(0, 1);
    chk("setm_wrap", {hour_bcd, min_bcd}, 16'h0500);

    btn_mode = 1;
    for (int i = 1; i <= 7 + TD; i++) begin
      step(1);
      if (i == 7) begin
        chk("exit_field", set_field, 0);
        chk("exit_sec", sec_bcd, 8'h00);
      end
      if (i > 7) chk("exit_tick", sec_tick, i == 7 + TD);
    end
    chk("exit_sec1", sec_bcd, 8'h01);
    btn_mode = 0;
    step(8);

    for (int k = 0; k < 300; k++) begin
      btn_mode = ($urandom_range(0, 5) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
      run_en   = ($urandom_range(0, 7) != 0);
      if (k == 150) begin
        @(posedge clock);
        #3 reset = 0;
        #1 chk("async_reset", outvec(), RST_VEC);
        @(negedge clock);
        reset = 1;
        step(1);
      end
      step($urandom_range(1, 10));
    end
    btn_mode = 0;
    btn_inc = 0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
